// File: rtl/interface_wheel_tx.sv
// interface_wheel_tx
// Quadrature encoder emulator. A command (direction + detent count) is turned
// into a Gray-code waveform on {pin2,pin1}, one full four-phase cycle per
// detent, each code held for PHASE_CYCLES clocks.
//   CW : 00 -> 01 -> 11 -> 10 -> 00
//   CCW: 00 -> 10 -> 11 -> 01 -> 00
// An abort in PH1..PH3 drops the pins to 00 for one dwell period so a receiver
// falls back to its start state without counting. An abort in PH4 lets the
// already-complete detent finish and tick, then stops.
module interface_wheel_tx #(
  parameter int PHASE_CYCLES = 4,
  parameter int STEP_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic              cmd_ready,
  input  logic              abort,
  output logic              pin1,
  output logic              pin2,
  output logic              busy,
  output logic              step_tick,
  output logic              done
);

  localparam int TIMER_W = (PHASE_CYCLES > 2) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(PHASE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PH1         = 3'd1,
    PH2         = 3'd2,
    PH3         = 3'd3,
    PH4         = 3'd4,
    ABORT_DWELL = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [STEP_W-1:0]   rem_q, rem_d;
  logic                dir_q, dir_d;
  logic                abort_pend_q, abort_pend_d;
  logic                pin1_q, pin1_d;
  logic                pin2_q, pin2_d;
  logic                busy_q, busy_d;
  logic                step_tick_q, step_tick_d;
  logic                done_q, done_d;

  logic                timer_last;
  logic                accept;

  assign timer_last = (timer_q == TIMER_LAST);
  assign cmd_ready  = (state_q == IDLE);
  assign accept     = cmd_valid && cmd_ready;

  assign pin1      = pin1_q;
  assign pin2      = pin2_q;
  assign busy      = busy_q;
  assign step_tick = step_tick_q;
  assign done      = done_q;

  // Next-state, phase timer, detent counter and pulse generation.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    rem_d        = rem_q;
    dir_d        = dir_q;
    abort_pend_d = abort_pend_q;
    step_tick_d  = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d      = '0;
        abort_pend_d = 1'b0;
        if (accept) begin
          dir_d = cmd_dir;
          rem_d = cmd_steps;
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = PH1;
          end
        end
      end

      PH1, PH2, PH3: begin
        if (abort) begin
          state_d = ABORT_DWELL;
          timer_d = '0;
          rem_d   = '0;
        end else if (timer_last) begin
          timer_d = '0;
          if (state_q == PH1) begin
            state_d = PH2;
          end else if (state_q == PH2) begin
            state_d = PH3;
          end else begin
            state_d = PH4;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      PH4: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        if (timer_last) begin
          timer_d     = '0;
          step_tick_d = 1'b1;
          if (abort || abort_pend_q) begin
            state_d      = IDLE;
            rem_d        = '0;
            abort_pend_d = 1'b0;
          end else begin
            rem_d = rem_q - 1'b1;
            if (rem_q > STEP_W'(1)) begin
              state_d = PH1;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ABORT_DWELL: begin
        if (timer_last) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d      = IDLE;
        timer_d      = '0;
        rem_d        = '0;
        abort_pend_d = 1'b0;
      end
    endcase
  end

  // Pin codes follow the next state so the registered pins line up with it.
  always_comb begin
    pin1_d = 1'b0;
    pin2_d = 1'b0;
    unique case (state_d)
      PH1: begin
        pin1_d = ~dir_d;
        pin2_d = dir_d;
      end
      PH2: begin
        pin1_d = 1'b1;
        pin2_d = 1'b1;
      end
      PH3: begin
        pin1_d = dir_d;
        pin2_d = ~dir_d;
      end
      default: begin
        pin1_d = 1'b0;
        pin2_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset forces the pins to 00 immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      rem_q        <= '0;
      dir_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      pin1_q       <= 1'b0;
      pin2_q       <= 1'b0;
      busy_q       <= 1'b0;
      step_tick_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      rem_q        <= rem_d;
      dir_q        <= dir_d;
      abort_pend_q <= abort_pend_d;
      pin1_q       <= pin1_d;
      pin2_q       <= pin2_d;
      busy_q       <= busy_d;
      step_tick_q  <= step_tick_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_interface_wheel_tx.sv
// tb_interface_wheel_tx
// Drives commands into interface_wheel_tx and compares every cycle of pins,
// busy, step_tick, done and cmd_ready against an arithmetic model of the
// expected waveform, indexed by cycle number after the accepting edge.
module tb_interface_wheel_tx;

  localparam int PC  = 4;
  localparam int SW  = 8;
  localparam int DET = 4 * PC;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir   = 1'b0;
  logic [SW-1:0] cmd_steps = '0;
  logic          abort     = 1'b0;
  logic          cmd_ready;
  logic          pin1;
  logic          pin2;
  logic          busy;
  logic          step_tick;
  logic          done;

  int compared   = 0;
  int mismatched = 0;

  // Model of the command in flight
  int mDir;
  int mAbort;
  int mEnd;
  int mTickLimit;
  bit mDwell;
  bit mDone;

  int cwSeq[4]  = '{1, 3, 2, 0};
  int ccwSeq[4] = '{2, 3, 1, 0};

  always #5 clk = ~clk;

  interface_wheel_tx #(
    .PHASE_CYCLES(PC),
    .STEP_W(SW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_dir(cmd_dir),
    .cmd_steps(cmd_steps),
    .cmd_ready(cmd_ready),
    .abort(abort),
    .pin1(pin1),
    .pin2(pin2),
    .busy(busy),
    .step_tick(step_tick),
    .done(done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Busy window length, tick range and done flag for one command.
  // a = cycle (1-based after accept) during which abort is held high, 0 = none.
  function automatic void planCommand(input int d, input int s, input int a);
    int phase;
    mDir       = d;
    mAbort     = a;
    mDwell     = 1'b0;
    mDone      = 1'b1;
    mEnd       = s * DET;
    mTickLimit = mEnd + 1;
    if (a > 0) begin
      phase = ((a - 1) % DET) / PC;
      mDone = 1'b0;
      if (phase < 3) begin
        mDwell     = 1'b1;
        mEnd       = a + PC;
        mTickLimit = a;
      end else begin
        mEnd       = ((a - 1) / DET + 1) * DET;
        mTickLimit = mEnd + 1;
      end
    end
  endfunction

  task automatic checkCycle(input int k);
    bit expBusy;
    bit expTick;
    bit expDone;
    int code;
    expBusy = (k <= mEnd);
    code = 0;
    if (expBusy && !(mDwell && k > mAbort)) begin
      code = (mDir != 0) ? ccwSeq[((k - 1) % DET) / PC] : cwSeq[((k - 1) % DET) / PC];
    end
    expTick = ((k - 1) % DET == 0) && (k > 1) && (k <= mTickLimit);
    expDone = mDone && (k == mEnd + 1);
    checkOutput($sformatf("pins@%0d", k), {30'd0, pin2, pin1}, code);
    checkOutput($sformatf("busy@%0d", k), {31'd0, busy}, {31'd0, expBusy});
    checkOutput($sformatf("step_tick@%0d", k), {31'd0, step_tick}, {31'd0, expTick});
    checkOutput($sformatf("done@%0d", k), {31'd0, done}, {31'd0, expDone});
    checkOutput($sformatf("cmd_ready@%0d", k), {31'd0, cmd_ready}, {31'd0, !expBusy});
  endtask

  // Issue one command from an IDLE negedge and follow it to its first IDLE cycle.
  // junk pulses an opposite-direction command while busy; abAcc raises abort
  // together with cmd_valid at the accepting edge.
  task automatic applyStimulus(input int d, input int s, input int a,
                               input bit junk, input bit abAcc);
    planCommand(d, s, a);
    cmd_valid = 1'b1;
    cmd_dir   = d[0];
    cmd_steps = SW'(s);
    abort     = abAcc;
    @(negedge clk);
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_steps = SW'($urandom_range(1, 255));
    for (int k = 1; k <= mEnd + 1; k++) begin
      checkCycle(k);
      abort     = (a > 0) && (k == a);
      cmd_valid = junk && (k <= mEnd) && (k % 5 == 2);
      cmd_dir   = ~d[0];
      if (k <= mEnd) @(negedge clk);
    end
    abort     = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic idleAbort();
    abort     = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("idle_abort busy", {31'd0, busy}, 32'd0);
    checkOutput("idle_abort pins", {30'd0, pin2, pin1}, 32'd0);
    checkOutput("idle_abort done", {31'd0, done}, 32'd0);
    checkOutput("idle_abort ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  // Reset asserted mid-PH3 of a CCW command must clear outputs without a clock.
  task automatic resetMidCommand();
    planCommand(1, 3, 0);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = SW'(3);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 2 * PC + 2; k++) begin
      checkCycle(k);
      if (k < 2 * PC + 2) @(negedge clk);
    end
    #2 reset = 1'b0;
    #1;
    checkOutput("rst pins", {30'd0, pin2, pin1}, 32'd0);
    checkOutput("rst busy", {31'd0, busy}, 32'd0);
    checkOutput("rst step_tick", {31'd0, step_tick}, 32'd0);
    checkOutput("rst done", {31'd0, done}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("post_rst ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("post_rst busy", {31'd0, busy}, 32'd0);
    checkOutput("post_rst pins", {30'd0, pin2, pin1}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d, s, a;
    bit junk, abAcc;
    #1 reset = 1'b0;
    #2;
    checkOutput("reset pins", {30'd0, pin2, pin1}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset step_tick", {31'd0, step_tick}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset ready", {31'd0, cmd_ready}, 32'd1);

    applyStimulus(0, 1, 0, 1'b0, 1'b0);
    applyStimulus(1, 3, 0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(0, 5, DET + PC + 2, 1'b0, 1'b0);
    applyStimulus(0, 2, 0, 1'b1, 1'b0);
    applyStimulus(1, 1, 0, 1'b0, 1'b0);
    applyStimulus(0, 2, 0, 1'b0, 1'b1);
    applyStimulus(1, 2, 3 * PC + 2, 1'b0, 1'b0);
    applyStimulus(0, 1, DET, 1'b0, 1'b0);
    applyStimulus(1, 2, 1, 1'b0, 1'b0);
    idleAbort();
    applyStimulus(0, 255, 0, 1'b0, 1'b0);
    resetMidCommand();

    for (int n = 0; n < 40; n++) begin
      d     = int'($urandom_range(0, 1));
      s     = int'($urandom_range(0, 5));
      a     = 0;
      if (s > 0 && $urandom_range(0, 2) == 0) a = int'($urandom_range(1, s * DET));
      junk  = ($urandom_range(0, 3) == 0);
      abAcc = ($urandom_range(0, 5) == 0);
      applyStimulus(d, s, a, junk, abAcc);
      if ($urandom_range(0, 3) == 0) idleAbort();
      else if ($urandom_range(0, 1) == 0) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
